// File: rtl/parking_lane_arbiter_if.sv
// Request/strobe bundle between the lane FSMs, the arbiter and the occupancy counter.
// Latency: none (wires only).
// Backpressure: none; requests are one-cycle pulses queued inside the arbiter.
interface parking_lane_arbiter_if #(
    parameter int CNT_W = 3
);
    logic             tick_1khz;
    logic [1:0]       in_req;
    logic [1:0]       out_req;
    logic             cnt_up;
    logic             cnt_dn;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;
    logic [1:0]       barrier;
    logic [1:0]       deny;
    logic             err;

    // Request side: lane FSMs and tick source.
    modport master (
        output tick_1khz, in_req, out_req,
        input  cnt_up, cnt_dn, occupancy, full, empty, barrier, deny, err
    );

    // Arbiter side.
    modport slave (
        input  tick_1khz, in_req, out_req,
        output cnt_up, cnt_dn, occupancy, full, empty, barrier, deny, err
    );
endinterface

// File: rtl/parking_lane_arbiter.sv
// Serialises two lanes' entry/exit pulses onto one occupancy counter, exits first, round-robin lanes.
// Latency: request pulse at cycle n -> strobe/deny/err visible at n+3; one request served per 2 cycles.
// Backpressure: none; each request type per lane queues one deep, duplicates are merged and flagged on err.
module parking_lane_arbiter #(
    parameter int CAPACITY   = 7,
    parameter int CNT_W      = 3,
    parameter int OPEN_TICKS = 2000,
    parameter int TMR_W      = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    parking_lane_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] CAP_V  = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] OPEN_V = TMR_W'(OPEN_TICKS);

    typedef enum logic {
        IDLE,
        SERVE
    } state_t;

    state_t           state;
    // Pending bits ordered {out1, out0, in1, in0}, so {is_exit, lane} indexes them directly.
    logic [3:0]       pending;
    logic [3:0]       req_vec;
    logic [3:0]       clr_vec;
    logic [3:0]       merge_vec;
    logic             sel_exit;
    logic             sel_lane;
    logic             rr;
    logic             win_exit;
    logic             win_lane;
    logic [1:0]       cls;
    logic             entry_ok;
    logic             entry_full;
    logic             exit_ok;
    logic             exit_empty;
    logic [1:0]       timer_load;
    logic [1:0]       deny_nxt;
    logic [CNT_W-1:0] occ_q;
    logic             cnt_up_q;
    logic             cnt_dn_q;
    logic             err_q;
    logic [1:0]       deny_q;
    logic [TMR_W-1:0] timer [2];

    assign req_vec   = {bus.out_req, bus.in_req};
    // A pulse landing on a bit that stays set is a duplicate. A pulse coinciding with the
    // bit being taken by the FSM re-arms it instead, so it is a fresh request, not a merge.
    assign merge_vec = req_vec & pending & ~clr_vec;

    // Winner selection: exits beat entries; inside a class the lane other than rr wins a tie.
    always_comb begin
        win_exit = (pending[3:2] != 2'b00);
        cls      = win_exit ? pending[3:2] : pending[1:0];
        win_lane = (cls == 2'b11) ? ~rr : cls[1];
        clr_vec  = 4'b0000;
        if (state == IDLE && pending != 4'b0000) begin
            clr_vec[{win_exit, win_lane}] = 1'b1;
        end
    end

    // Outcome of the request currently in SERVE, and which lane's barrier it opens or denies.
    always_comb begin
        entry_ok   = (state == SERVE) && !sel_exit && (occ_q < CAP_V);
        entry_full = (state == SERVE) && !sel_exit && !(occ_q < CAP_V);
        exit_ok    = (state == SERVE) &&  sel_exit && (occ_q != '0);
        exit_empty = (state == SERVE) &&  sel_exit && (occ_q == '0);
        timer_load = 2'b00;
        deny_nxt   = 2'b00;
        if (entry_ok || exit_ok) begin
            timer_load[sel_lane] = 1'b1;
        end
        if (entry_full) begin
            deny_nxt[sel_lane] = 1'b1;
        end
    end

    // Pending request register; a new pulse wins over the FSM clearing the same bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 4'b0000;
        end else begin
            pending <= (pending & ~clr_vec) | req_vec;
        end
    end

    // Serve FSM with the shadow occupancy and registered strobe/deny/err outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel_exit <= 1'b0;
            sel_lane <= 1'b0;
            rr       <= 1'b0;
            occ_q    <= '0;
            cnt_up_q <= 1'b0;
            cnt_dn_q <= 1'b0;
            deny_q   <= 2'b00;
            err_q    <= 1'b0;
        end else begin
            cnt_up_q <= entry_ok;
            cnt_dn_q <= exit_ok;
            deny_q   <= deny_nxt;
            err_q    <= exit_empty || (merge_vec != 4'b0000);
            if (entry_ok) begin
                occ_q <= occ_q + CNT_W'(1);
            end else if (exit_ok) begin
                occ_q <= occ_q - CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (pending != 4'b0000) begin
                        sel_exit <= win_exit;
                        sel_lane <= win_lane;
                        state    <= SERVE;
                    end
                end
                SERVE: begin
                    rr    <= sel_lane;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Barrier hold timers: a reload beats a coincident tick, otherwise count ticks down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (timer_load[i]) begin
                    timer[i] <= OPEN_V;
                end else if (bus.tick_1khz && timer[i] != '0) begin
                    timer[i] <= timer[i] - TMR_W'(1);
                end
            end
        end
    end

    assign bus.cnt_up    = cnt_up_q;
    assign bus.cnt_dn    = cnt_dn_q;
    assign bus.occupancy = occ_q;
    assign bus.full      = (occ_q == CAP_V);
    assign bus.empty     = (occ_q == '0);
    assign bus.deny      = deny_q;
    assign bus.err       = err_q;
    assign bus.barrier   = {timer[1] != '0, timer[0] != '0};
endmodule

// File: tb/tb_parking_lane_arbiter.sv
// Directed bench for parking_lane_arbiter: a per-cycle vector table plus hand sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_parking_lane_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    parking_lane_arbiter_if #(.CNT_W(3)) bus ();

    parking_lane_arbiter #(
        .CAPACITY  (7),
        .CNT_W     (3),
        .OPEN_TICKS(2000),
        .TMR_W     (12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // exp = {cnt_up, cnt_dn, occupancy[2:0], full, empty, barrier[1:0], deny[1:0], err}
    typedef struct {
        logic        rst;
        logic [1:0]  in_req;
        logic [1:0]  out_req;
        logic [11:0] exp;
    } vec_t;

    localparam int NROWS = 29;
    vec_t tbl [NROWS];

    function automatic vec_t mk(input logic r, input logic [1:0] inr, input logic [1:0] outr,
                                input logic up, input logic dn, input logic [2:0] occ,
                                input logic [1:0] bar, input logic [1:0] dny, input logic er);
        vec_t v;
        v.rst     = r;
        v.in_req  = inr;
        v.out_req = outr;
        v.exp     = {up, dn, occ, (occ == 3'd7), (occ == 3'd0), bar, dny, er};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_req    = 2'b00;
        bus.out_req   = 2'b00;
        bus.tick_1khz = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Pulse in_req and count edges until cnt_up shows, bounded at 10.
    task automatic entry_latency(input logic [1:0] lanes, output int e);
        bus.in_req = lanes;
        step();
        bus.in_req = 2'b00;
        e = 1;
        while (!bus.cnt_up && e < 10) begin
            step();
            e++;
        end
    endtask

    logic [11:0] outs;
    int          e;
    int          ups;
    int          dens;

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.in_req    = 2'b00;
        bus.out_req   = 2'b00;
        bus.tick_1khz = 1'b0;

        //               rst  in     out    up dn occ bar    deny   err
        tbl[0]  = mk(1'b1, 2'b00, 2'b00, 0, 0, 3'd0, 2'b00, 2'b00, 0);
        // exit on lane 1 while empty
        tbl[1]  = mk(1'b0, 2'b00, 2'b10, 0, 0, 3'd0, 2'b00, 2'b00, 0);
        tbl[2]  = mk(1'b0, 2'b00, 2'b00, 0, 0, 3'd0, 2'b00, 2'b00, 0);
        tbl[3]  = mk(1'b0, 2'b00, 2'b00, 0, 0, 3'd0, 2'b00, 2'b00, 1);
        tbl[4]  = mk(1'b0, 2'b00, 2'b00, 0, 0, 3'd0, 2'b00, 2'b00, 0);
        // three entries on lane 0, back to back at full throughput
        tbl[5]  = mk(1'b0, 2'b01, 2'b00, 0, 0, 3'd0, 2'b00, 2'b00, 0);
        tbl[6]  = mk(1'b0, 2'b00, 2'b00, 0, 0, 3'd0, 2'b00, 2'b00, 0);
        tbl[7]  = mk(1'b0, 2'b01, 2'b00, 1, 0, 3'd1, 2'b01, 2'b00, 0);
        tbl[8]  = mk(1'b0, 2'b00, 2'b00, 0, 0, 3'd1, 2'b01, 2'b00, 0);
        tbl[9]  = mk(1'b0, 2'b01, 2'b00, 1, 0, 3'd2, 2'b01, 2'b00, 0);
        tbl[10] = mk(1'b0, 2'b00, 2'b00, 0, 0, 3'd2, 2'b01, 2'b00, 0);
        tbl[11] = mk(1'b0, 2'b00, 2'b00, 1, 0, 3'd3, 2'b01, 2'b00, 0);
        tbl[12] = mk(1'b0, 2'b00, 2'b00, 0, 0, 3'd3, 2'b01, 2'b00, 0);
        // occupancy 3: both entries and exit 0 at once -> exit0, entry1, entry0
        tbl[13] = mk(1'b0, 2'b11, 2'b01, 0, 0, 3'd3, 2'b01, 2'b00, 0);
        tbl[14] = mk(1'b0, 2'b00, 2'b00, 0, 0, 3'd3, 2'b01, 2'b00, 0);
        tbl[15] = mk(1'b0, 2'b00, 2'b00, 0, 1, 3'd2, 2'b01, 2'b00, 0);
        tbl[16] = mk(1'b0, 2'b00, 2'b00, 0, 0, 3'd2, 2'b01, 2'b00, 0);
        tbl[17] = mk(1'b0, 2'b00, 2'b00, 1, 0, 3'd3, 2'b11, 2'b00, 0);
        tbl[18] = mk(1'b0, 2'b00, 2'b00, 0, 0, 3'd3, 2'b11, 2'b00, 0);
        tbl[19] = mk(1'b0, 2'b00, 2'b00, 1, 0, 3'd4, 2'b11, 2'b00, 0);
        tbl[20] = mk(1'b0, 2'b00, 2'b00, 0, 0, 3'd4, 2'b11, 2'b00, 0);
        // both entries; lane 0 re-pulsed while still queued -> merged, err once, one strobe
        tbl[21] = mk(1'b0, 2'b11, 2'b00, 0, 0, 3'd4, 2'b11, 2'b00, 0);
        tbl[22] = mk(1'b0, 2'b00, 2'b00, 0, 0, 3'd4, 2'b11, 2'b00, 0);
        tbl[23] = mk(1'b0, 2'b01, 2'b00, 1, 0, 3'd5, 2'b11, 2'b00, 1);
        tbl[24] = mk(1'b0, 2'b00, 2'b00, 0, 0, 3'd5, 2'b11, 2'b00, 0);
        tbl[25] = mk(1'b0, 2'b00, 2'b00, 1, 0, 3'd6, 2'b11, 2'b00, 0);
        tbl[26] = mk(1'b0, 2'b00, 2'b00, 0, 0, 3'd6, 2'b11, 2'b00, 0);
        tbl[27] = mk(1'b0, 2'b00, 2'b00, 0, 0, 3'd6, 2'b11, 2'b00, 0);
        tbl[28] = mk(1'b0, 2'b00, 2'b00, 0, 0, 3'd6, 2'b11, 2'b00, 0);

        for (int r = 0; r < NROWS; r++) begin
            rst         = tbl[r].rst;
            bus.in_req  = tbl[r].in_req;
            bus.out_req = tbl[r].out_req;
            step();
            outs = {bus.cnt_up, bus.cnt_dn, bus.occupancy, bus.full, bus.empty,
                    bus.barrier, bus.deny, bus.err};
            check($sformatf("row%0d", r), 32'(outs), 32'(tbl[r].exp));
        end
        bus.in_req  = 2'b00;
        bus.out_req = 2'b00;

        // Single entry: latency, barrier hold of exactly 2000 ticks.
        do_reset();
        check("rst_occ", 32'(bus.occupancy), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_barrier", 32'(bus.barrier), 32'd0);
        entry_latency(2'b01, e);
        check("t1_latency", 32'(e), 32'd3);
        check("t1_occ", 32'(bus.occupancy), 32'd1);
        check("t1_barrier_open", 32'(bus.barrier), 32'b01);
        bus.tick_1khz = 1'b1;
        repeat (1999) step();
        check("t1_barrier_1999", 32'(bus.barrier), 32'b01);
        step();
        check("t1_barrier_2000", 32'(bus.barrier), 32'b00);
        bus.tick_1khz = 1'b0;

        // Fill to capacity on lane 1, then one more entry is denied.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            bus.in_req = 2'b10;
            step();
            bus.in_req = 2'b00;
            step();
        end
        repeat (3) step();
        check("t2_occ7", 32'(bus.occupancy), 32'd7);
        check("t2_full", 32'(bus.full), 32'd1);
        bus.in_req = 2'b10;
        step();
        bus.in_req = 2'b00;
        ups  = 0;
        dens = 0;
        repeat (5) begin
            step();
            if (bus.cnt_up) ups++;
            if (bus.deny == 2'b10) dens++;
        end
        check("t2_no_up", 32'(ups), 32'd0);
        check("t2_deny_once", 32'(dens), 32'd1);
        check("t2_occ_hold", 32'(bus.occupancy), 32'd7);

        // Reset while an entry is in SERVE and another is queued.
        do_reset();
        entry_latency(2'b01, e);
        step();
        check("t6_pre_occ", 32'(bus.occupancy), 32'd1);
        check("t6_pre_barrier", 32'(bus.barrier), 32'b01);
        bus.in_req = 2'b11;
        step();
        bus.in_req = 2'b00;
        step();
        rst = 1'b1;
        #1;
        check("t6_rst_occ", 32'(bus.occupancy), 32'd0);
        check("t6_rst_barrier", 32'(bus.barrier), 32'b00);
        step();
        rst = 1'b0;
        ups = 0;
        repeat (6) begin
            step();
            if (bus.cnt_up) ups++;
        end
        check("t6_dropped", 32'(ups), 32'd0);
        check("t6_occ_after", 32'(bus.occupancy), 32'd0);
        entry_latency(2'b01, e);
        check("t6_next_latency", 32'(e), 32'd3);
        check("t6_next_occ", 32'(bus.occupancy), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
